encryption_engine: RTL and testbench

ENCRYPTION_ENGINE -- requirements
Module: encryption_engine

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/aes_round_key_gen.sv | 28 ++
 rtl/encryption_engine.sv | 170 +++++++++++++++++
 tb/tb_encryption_engine.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM encoding, round count, S-box, Rcon and GF(2^8) helpers.
package aes_pkg;

   localparam logic [3:0] NUM_ROUNDS = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_FINAL = 2'd2
   } aes_state_e;

   localparam logic [79:0] RCON_TBL = 80'h01_02_04_08_10_20_40_80_1b_36;

   // Byte 0x00 sits in the top byte, so entry b lives at bit offset (255-b)*8.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Round numbers 1..10 map to the Rcon entries; anything else yields zero.
   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      logic [7:0] r;
      r = 8'h00;
      if (rnd != 4'd0 && rnd <= NUM_ROUNDS) begin
         r = RCON_TBL[8*(10 - int'(rnd)) +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_round_key_gen.sv
// Combinational AES-128 key schedule step: next round key from current key and round number.
module aes_round_key_gen
   import aes_pkg::*;
(
   input  logic [127:0] rk_i,
   input  logic [3:0]   round_i,
   output logic [127:0] nk_o
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] temp;
   logic [31:0] n0, n1, n2, n3;

   assign w0 = rk_i[127:96];
   assign w1 = rk_i[95:64];
   assign w2 = rk_i[63:32];
   assign w3 = rk_i[31:0];

   assign temp = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(round_i), 24'h000000};

   assign n0 = w0 ^ temp;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign nk_o = {n0, n1, n2, n3};

endmodule

// File: rtl/encryption_engine.sv
// Iterative AES-128 encryption core, one round per step with on-the-fly key expansion.
// Build option AES_ENC_SBOX_PIPE_EN registers SubBytes/SubWord, making each round two cycles.
//
// state    | meaning
// ST_IDLE  | waiting for start; ciphertext holds last result
// ST_ROUND | rounds 1..9 (SubBytes, ShiftRows, MixColumns, AddRoundKey)
// ST_FINAL | round 10 without MixColumns; loads ciphertext, pulses done
module encryption_engine
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic [127:0] ciphertext,
   output logic         busy,
   output logic         done
);

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) begin
         o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      end
      return o;
   endfunction

   // Byte 4c+r is row r of column c; row r rotates left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++) begin
         o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
      end
      return o;
   endfunction

   aes_state_e   state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [127:0] st_q, st_d;
   logic [127:0] rk_q, rk_d;
   logic [127:0] ct_q, ct_d;
   logic         done_q, done_d;

   logic [127:0] nk;
   logic [127:0] sb_use;
   logic [127:0] nk_use;
   logic         adv;
   logic [127:0] sr;
   logic [127:0] mc;

   aes_round_key_gen u_key_gen (
      .rk_i    (rk_q),
      .round_i (cnt_q),
      .nk_o    (nk)
   );

`ifdef AES_ENC_SBOX_PIPE_EN
   // phase_q=0: capture S-box outputs; phase_q=1: finish the round from the captured values.
   logic         phase_q;
   logic [127:0] sb_q;
   logic [127:0] nkp_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q <= 1'b0;
         sb_q    <= '0;
         nkp_q   <= '0;
      end else begin
         phase_q <= (state_q != ST_IDLE) ? ~phase_q : 1'b0;
         sb_q    <= sub_bytes(st_q);
         nkp_q   <= nk;
      end
   end

   assign adv    = phase_q;
   assign sb_use = sb_q;
   assign nk_use = nkp_q;
`else
   assign adv    = 1'b1;
   assign sb_use = sub_bytes(st_q);
   assign nk_use = nk;
`endif

   assign sr = shift_rows(sb_use);
   assign mc = mix_columns(sr);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      st_d    = st_q;
      rk_d    = rk_q;
      ct_d    = ct_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               st_d    = plaintext ^ key;
               rk_d    = key;
               cnt_d   = 4'd1;
               state_d = ST_ROUND;
            end
         end
         ST_ROUND: begin
            if (adv) begin
               st_d  = mc ^ nk_use;
               rk_d  = nk_use;
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == NUM_ROUNDS - 4'd1) begin
                  state_d = ST_FINAL;
               end
            end
         end
         ST_FINAL: begin
            if (adv) begin
               ct_d    = sr ^ nk_use;
               cnt_d   = 4'd0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         st_q    <= '0;
         rk_q    <= '0;
         ct_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         st_q    <= st_d;
         rk_q    <= rk_d;
         ct_q    <= ct_d;
         done_q  <= done_d;
      end
   end

   assign ciphertext = ct_q;
   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q;

endmodule

// File: tb/tb_encryption_engine.sv
// Self-checking bench for encryption_engine: known-answer vectors, control corner cases
// and random blocks against a from-first-principles AES-128 model.
module tb_encryption_engine;

`ifdef AES_ENC_SBOX_PIPE_EN
   localparam int LAT = 20;
`else
   localparam int LAT = 10;
`endif

   localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic [127:0] plaintext;
   logic [127:0] key;
   logic [127:0] ciphertext;
   logic         busy;
   logic         done;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] sbox_ref [256];

   always #5 clk = ~clk;

   encryption_engine dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .plaintext  (plaintext),
      .key        (key),
      .ciphertext (ciphertext),
      .busy       (busy),
      .done       (done)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in;
      b = b_in;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
   task automatic build_sbox();
      logic [7:0] x, inv;
      for (int v = 0; v < 256; v++) begin
         x = v[7:0];
         inv = 8'h00;
         if (v != 0) begin
            for (int y = 1; y < 256; y++) begin
               if (gmul(x, y[7:0]) == 8'h01) inv = y[7:0];
            end
         end
         sbox_ref[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                       ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   u [16];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [127:0] o;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox_ref[tmp[23:16]], sbox_ref[tmp[15:8]], sbox_ref[tmp[7:0]], sbox_ref[tmp[31:24]]}
                  ^ {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int j = 0; j < 16; j++) begin
         tmp  = w[j/4];
         s[j] = pt[127-8*j -: 8] ^ tmp[31-8*(j%4) -: 8];
      end
      for (int r = 1; r <= 10; r++) begin
         for (int j = 0; j < 16; j++) s[j] = sbox_ref[s[j]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               t[4*c+row] = s[4*((c+row)%4)+row];
         for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++)
               u[4*c+i] = (r == 10) ? t[4*c+i] :
                          gmul(8'h02, t[4*c+i]) ^ gmul(8'h03, t[4*c+(i+1)%4])
                          ^ t[4*c+(i+2)%4] ^ t[4*c+(i+3)%4];
         for (int j = 0; j < 16; j++) begin
            tmp  = w[4*r + j/4];
            s[j] = u[j] ^ tmp[31-8*(j%4) -: 8];
         end
      end
      for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s[j];
      return o;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_block(input logic [127:0] p, input logic [127:0] k);
      plaintext = p;
      key       = k;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   // Called one cycle after the start edge; returns in the done cycle with lat = edges since start.
   task automatic wait_done(input string tag, input bit hold_en, input logic [127:0] hold_val,
                            output int lat);
      lat = 0;
      while (!done && lat < LAT + 20) begin
         check({tag, " busy"}, {127'd0, busy}, 128'd1);
         if (hold_en) check({tag, " hold"}, ciphertext, hold_val);
         tick();
         lat++;
      end
      if (!done) check({tag, " timeout"}, {127'd0, done}, 128'd1);
      check({tag, " busy at done"}, {127'd0, busy}, 128'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int ndone;
      int seen;
      logic [127:0] got_ct;
      logic [127:0] exp_ct;
      logic [127:0] rp, rk;

      reset_n   = 1'b0;
      start     = 1'b0;
      plaintext = '0;
      key       = '0;
      build_sbox();
      check("model v1", ref_encrypt(K1, P1), C1);

      repeat (3) tick();
      check("reset ct", ciphertext, 128'd0);
      check("reset busy", {127'd0, busy}, 128'd0);
      check("reset done", {127'd0, done}, 128'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // FIPS-197 appendix C vector, first start right after reset release
      start_block(P1, K1);
      wait_done("v1", 1'b0, '0, lat);
      check("v1 latency", 128'(lat), 128'(LAT));
      check("v1 ct", ciphertext, C1);
      tick();
      check("v1 done single", {127'd0, done}, 128'd0);

      start_block(P2, K2);
      wait_done("v2", 1'b1, C1, lat);
      check("v2 latency", 128'(lat), 128'(LAT));
      check("v2 ct", ciphertext, C2);
      tick();

      // zero vector, then back-to-back start in the done cycle
      start_block('0, '0);
      wait_done("v0", 1'b0, '0, lat);
      check("v0 latency", 128'(lat), 128'(LAT));
      check("v0 ct", ciphertext, C0);
      start_block(P2, K2);
      wait_done("b2b", 1'b1, C0, lat);
      check("b2b latency", 128'(lat), 128'(LAT));
      check("b2b ct", ciphertext, C2);
      tick();

      // start re-pulsed mid-block with other data must be ignored
      start_block(P1, K1);
      ndone  = 0;
      lat    = 0;
      got_ct = '0;
      for (int c = 1; c <= LAT + 6; c++) begin
         if (c == 3 || c == 7) begin
            plaintext = rand128();
            key       = rand128();
            start     = 1'b1;
         end else begin
            start     = 1'b0;
         end
         tick();
         if (done) begin
            ndone++;
            lat    = c;
            got_ct = ciphertext;
         end
      end
      check("repulse done count", 128'(ndone), 128'd1);
      check("repulse latency", 128'(lat), 128'(LAT));
      check("repulse ct", got_ct, C1);

      // reset in the middle of a block aborts it
      start_block(P2, K2);
      repeat (4) tick();
      reset_n = 1'b0;
      #1;
      check("abort ct", ciphertext, 128'd0);
      check("abort busy", {127'd0, busy}, 128'd0);
      check("abort done", {127'd0, done}, 128'd0);
      seen = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (done) seen++;
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < LAT + 3; c++) begin
         tick();
         if (done || busy) seen++;
      end
      check("abort no done", 128'(seen), 128'd0);
      start_block(P1, K1);
      wait_done("post reset", 1'b1, 128'd0, lat);
      check("post reset latency", 128'(lat), 128'(LAT));
      check("post reset ct", ciphertext, C1);
      tick();

      // random blocks against the reference model, some back-to-back
      for (int n = 0; n < 8; n++) begin
         rp     = rand128();
         rk     = rand128();
         exp_ct = ref_encrypt(rk, rp);
         start_block(rp, rk);
         wait_done("rand", 1'b0, '0, lat);
         check("rand latency", 128'(lat), 128'(LAT));
         check("rand ct", ciphertext, exp_ct);
         if (n % 2 == 0) tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
